// File: rtl/sub_pipe_pkg.sv
// Shared definitions for the pipelined ripple-borrow subtractor.
// Default geometry, slice-width derivation and the per-stage control record.
package sub_pipe_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_of(input int width, input int stages);
        return width / stages;
    endfunction

    // Control half of a stage record; the operand tail / diff head travel beside it.
    typedef struct packed {
        logic vld;
        logic borrow;
    } stage_ctl_t;

endpackage

// File: rtl/rb_sub_slice.sv
// Combinational CHUNK-bit ripple-borrow subtract slice.
// {bout, d} = a - b - bin evaluated one bit wider than the slice.
module rb_sub_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    assign d    = full[CHUNK-1:0];
    assign bout = full[CHUNK];

endmodule

// File: rtl/pipeline_rb_subtractor.sv
// Pipelined ripple-borrow subtractor with valid/ready flow control.
// Stage k resolves operand slice k; unresolved operand slices and finished diff slices ride along.
module pipeline_rb_subtractor
    import sub_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CHUNK = chunk_of(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipeline_rb_subtractor: WIDTH must be a multiple of STAGES");
    end

    stage_ctl_t       ctl_q  [STAGES];
    // res_q: minuend slices above this stage merged with finished diff slices below it
    logic [WIDTH-1:0] res_q  [STAGES];
    // brem_q: subtrahend slices not yet consumed, right-aligned
    logic [WIDTH-1:0] brem_q [STAGES];

    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] b_src  [STAGES];
    logic [WIDTH-1:0] res_d  [STAGES];
    logic [WIDTH-1:0] brem_d [STAGES];
    logic [CHUNK-1:0] d_s    [STAGES];
    logic [STAGES-1:0] bin_src;
    logic [STAGES-1:0] bo;
    logic [STAGES-1:0] vld_in;
    logic [STAGES:0]   go;

    // Ready chain: a stage may load when empty or when its content moves on.
    always_comb begin
        go         = '0;
        go[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go[k] = ~ctl_q[k].vld | go[k+1];
        end
    end

    assign in_ready = go[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_src[k]   = a;
            assign b_src[k]   = b;
            assign bin_src[k] = bin;
            assign vld_in[k]  = in_valid;
        end else begin : g_body
            assign a_src[k]   = res_q[k-1];
            assign b_src[k]   = brem_q[k-1];
            assign bin_src[k] = ctl_q[k-1].borrow;
            assign vld_in[k]  = ctl_q[k-1].vld;
        end

        rb_sub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (a_src[k][k*CHUNK +: CHUNK]),
            .b    (b_src[k][CHUNK-1:0]),
            .bin  (bin_src[k]),
            .d    (d_s[k]),
            .bout (bo[k])
        );

        assign res_d[k]  = (a_src[k] & ~(SLICE_MASK << (k * CHUNK)))
                         | (WIDTH'(d_s[k]) << (k * CHUNK));
        assign brem_d[k] = b_src[k] >> CHUNK;
    end

    // Data registers only capture real operations, so the output keeps its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k]  <= '0;
                res_q[k]  <= '0;
                brem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (go[k]) begin
                    ctl_q[k].vld <= vld_in[k];
                    if (vld_in[k]) begin
                        ctl_q[k].borrow <= bo[k];
                        res_q[k]        <= res_d[k];
                        brem_q[k]       <= brem_d[k];
                    end
                end
            end
        end
    end

    assign out_valid = ctl_q[STAGES-1].vld;
    assign diff      = res_q[STAGES-1];
    assign bout      = ctl_q[STAGES-1].borrow;

endmodule

// File: tb/tb_pipeline_rb_subtractor.sv
// Self-checking bench for pipeline_rb_subtractor: directed scenarios plus a
// queue scoreboard on a 64/4 instance and a 32/8 instance.
module tb_pipeline_rb_subtractor;

    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv_w, ir_w, ov_w, or_w, bin_w, bout_w;
    logic [63:0] a_w, b_w, diff_w;
    logic        iv_n, ir_n, ov_n, or_n, bin_n, bout_n;
    logic [31:0] a_n, b_n, diff_n;

    int checks = 0;
    int errors = 0;

    logic [64:0] q_w [$];
    logic [32:0] q_n [$];
    logic [64:0] exp_w;
    logic [32:0] exp_n;

    pipeline_rb_subtractor #(.WIDTH(64), .STAGES(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w),
        .a(a_w), .b(b_w), .bin(bin_w), .out_valid(ov_w), .out_ready(or_w),
        .diff(diff_w), .bout(bout_w)
    );

    pipeline_rb_subtractor #(.WIDTH(32), .STAGES(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(ir_n),
        .a(a_n), .b(b_n), .bin(bin_n), .out_valid(ov_n), .out_ready(or_n),
        .diff(diff_n), .bout(bout_n)
    );

    function automatic logic [64:0] model_w(input logic [63:0] a, input logic [63:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {64'd0, bi};
    endfunction

    function automatic logic [32:0] model_n(input logic [31:0] a, input logic [31:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {32'd0, bi};
    endfunction

    // Scoreboards: handshakes are sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_w.delete();
        end else begin
            if (iv_w && ir_w) q_w.push_back(model_w(a_w, b_w, bin_w));
            if (ov_w && or_w) begin
                checks++;
                if (q_w.size() == 0) begin
                    errors++;
                    $display("FAIL sb_w: unexpected result bout=%b diff=%h, none required", bout_w, diff_w);
                end else begin
                    exp_w = q_w.pop_front();
                    if ({bout_w, diff_w} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_w: got bout=%b diff=%h, required bout=%b diff=%h",
                                 bout_w, diff_w, exp_w[64], exp_w[63:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_n.delete();
        end else begin
            if (iv_n && ir_n) q_n.push_back(model_n(a_n, b_n, bin_n));
            if (ov_n && or_n) begin
                checks++;
                if (q_n.size() == 0) begin
                    errors++;
                    $display("FAIL sb_n: unexpected result bout=%b diff=%h, none required", bout_n, diff_n);
                end else begin
                    exp_n = q_n.pop_front();
                    if ({bout_n, diff_n} !== exp_n) begin
                        errors++;
                        $display("FAIL sb_n: got bout=%b diff=%h, required bout=%b diff=%h",
                                 bout_n, diff_n, exp_n[32], exp_n[31:0]);
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put_w(input logic v, input logic [63:0] a, input logic [63:0] b, input logic bi);
        iv_w  = v;
        a_w   = a;
        b_w   = b;
        bin_w = bi;
    endtask

    task automatic drain_w(input string name);
        for (int n = 0; n < 40 && (q_w.size() != 0 || ov_w); n++) cycle();
        checks++;
        if (q_w.size() != 0 || ov_w) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, out_valid=%b, required 0 and 0", name, q_w.size(), ov_w);
        end
    endtask

    task automatic test_reset_state();
        #1;
        checks++;
        if (ov_w !== 1'b0 || diff_w !== 64'd0 || bout_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b diff=%h bout=%b, required 0 0 0", ov_w, diff_w, bout_w);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        checks++;
        if (ir_w !== 1'b1 || ov_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1 0", ir_w, ov_w);
        end
    endtask

    task automatic test_basic();
        or_w = 1'b1;
        put_w(1'b1, 64'd100, 64'd58, 1'b0);
        cycle();
        iv_w = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (ov_w !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency: out_valid=%b at cycle %0d, required 0", ov_w, i);
            end
            cycle();
        end
        checks++;
        if (ov_w !== 1'b1 || diff_w !== 64'd42 || bout_w !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: out_valid=%b diff=%0d bout=%b, required 1 42 0", ov_w, diff_w, bout_w);
        end
        drain_w("basic");
    endtask

    task automatic test_borrow();
        int n;
        put_w(1'b1, 64'd0, 64'd1, 1'b0);
        cycle();
        put_w(1'b1, 64'h1_0000_0000, 64'd0, 1'b1);
        cycle();
        iv_w = 1'b0;
        n = 0;
        while (!ov_w && n < 8) begin
            cycle();
            n++;
        end
        checks++;
        if (ov_w !== 1'b1 || diff_w !== 64'hFFFF_FFFF_FFFF_FFFF || bout_w !== 1'b1) begin
            errors++;
            $display("FAIL borrow_all: out_valid=%b diff=%h bout=%b, required 1 ffffffffffffffff 1", ov_w, diff_w, bout_w);
        end
        cycle();
        checks++;
        if (ov_w !== 1'b1 || diff_w !== 64'h0000_0000_FFFF_FFFF || bout_w !== 1'b0) begin
            errors++;
            $display("FAIL borrow_bin: out_valid=%b diff=%h bout=%b, required 1 00000000ffffffff 0", ov_w, diff_w, bout_w);
        end
        drain_w("borrow");
    endtask

    task automatic test_reset_mid();
        logic seen;
        for (int i = 0; i < 3; i++) begin
            put_w(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cycle();
        end
        iv_w = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov_w !== 1'b0 || diff_w !== 64'd0 || bout_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b diff=%h bout=%b, required 0 0 0", ov_w, diff_w, bout_w);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir_w !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: in_ready=%b, required 1", ir_w);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (ov_w) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale: out_valid pulsed=%b after release, required 0", seen);
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] oa [6];
        logic [63:0] ob [6];
        logic        obi [6];
        logic [64:0] first;
        logic [63:0] held;
        int          acc;
        logic        took;
        for (int i = 0; i < 6; i++) begin
            oa[i]  = {$urandom, $urandom};
            ob[i]  = {$urandom, $urandom};
            obi[i] = 1'(i % 2);
        end
        first = model_w(oa[0], ob[0], obi[0]);
        or_w = 1'b0;
        acc  = 0;
        for (int c = 0; c < 8; c++) begin
            put_w(1'b1, oa[acc], ob[acc], obi[acc]);
            took = ir_w;
            cycle();
            if (took) acc++;
        end
        checks++;
        if (acc != 4 || ir_w !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepts=%0d in_ready=%b, required 4 0", acc, ir_w);
        end
        held = diff_w;
        checks++;
        if (ov_w !== 1'b1 || {bout_w, diff_w} !== first) begin
            errors++;
            $display("FAIL bp_head: out_valid=%b bout=%b diff=%h, required 1 %b %h", ov_w, bout_w, diff_w, first[64], first[63:0]);
        end
        repeat (3) cycle();
        checks++;
        if (ov_w !== 1'b1 || diff_w !== held) begin
            errors++;
            $display("FAIL bp_stable: out_valid=%b diff=%h, required 1 %h", ov_w, diff_w, held);
        end
        or_w = 1'b1;
        #1;
        checks++;
        if (ir_w !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_rise: in_ready=%b, required 1", ir_w);
        end
        for (int c = 0; c < 20 && acc < 6; c++) begin
            put_w(1'b1, oa[acc], ob[acc], obi[acc]);
            took = ir_w;
            cycle();
            if (took) acc++;
        end
        iv_w = 1'b0;
        checks++;
        if (acc != 6) begin
            errors++;
            $display("FAIL bp_accepts: accepts=%0d, required 6", acc);
        end
        drain_w("bp");
    endtask

    task automatic test_bubbles();
        int pat [4] = '{1, 0, 1, 0};
        int sq  [4] = '{1, 1, 0, 1};
        or_w = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) put_w(1'(pat[c]), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            else iv_w = 1'b0;
            if (c >= 4) begin
                checks++;
                if (ov_w !== 1'(pat[c-4])) begin
                    errors++;
                    $display("FAIL bubble_pattern: out_valid=%b at cycle %0d, required %0d", ov_w, c, pat[c-4]);
                end
            end
            cycle();
        end
        drain_w("bubble");

        or_w = 1'b0;
        for (int c = 0; c < 4; c++) begin
            put_w(1'(sq[c]), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cycle();
        end
        checks++;
        if (ir_w !== 1'b1) begin
            errors++;
            $display("FAIL squeeze_ready: in_ready=%b with bubble in stage 1, required 1", ir_w);
        end
        put_w(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        cycle();
        put_w(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        checks++;
        if (ir_w !== 1'b0) begin
            errors++;
            $display("FAIL squeeze_full: in_ready=%b after extra accept, required 0", ir_w);
        end
        cycle();
        checks++;
        if (ir_w !== 1'b0 || ov_w !== 1'b1) begin
            errors++;
            $display("FAIL squeeze_hold: in_ready=%b out_valid=%b, required 0 1", ir_w, ov_w);
        end
        or_w = 1'b1;
        cycle();
        iv_w = 1'b0;
        drain_w("squeeze");
    endtask

    task automatic test_random();
        fork
            begin
                int   acc_w = 0;
                int   cyc_w = 0;
                logic took_w = 1'b1;
                while (acc_w < N_RAND && cyc_w < 60000) begin
                    if (!iv_w || took_w) begin
                        iv_w  = ($urandom_range(0, 3) != 0);
                        a_w   = {$urandom, $urandom};
                        b_w   = {$urandom, $urandom};
                        bin_w = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 7))
                            0: a_w = '0;
                            1: b_w = '1;
                            2: begin a_w = '1; b_w = '1; end
                            default: ;
                        endcase
                    end
                    or_w = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    took_w = iv_w && ir_w;
                    if (took_w) acc_w++;
                    @(posedge clk);
                    #1;
                    cyc_w++;
                end
                iv_w = 1'b0;
                or_w = 1'b1;
                checks++;
                if (acc_w < N_RAND) begin
                    errors++;
                    $display("FAIL random_w_timeout: accepts=%0d, required %0d", acc_w, N_RAND);
                end
            end
            begin
                int   acc_n = 0;
                int   cyc_n = 0;
                logic took_n = 1'b1;
                while (acc_n < N_RAND && cyc_n < 60000) begin
                    if (!iv_n || took_n) begin
                        iv_n  = ($urandom_range(0, 3) != 0);
                        a_n   = $urandom;
                        b_n   = $urandom;
                        bin_n = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 7))
                            0: a_n = '0;
                            1: b_n = '1;
                            2: begin a_n = '1; b_n = '1; end
                            default: ;
                        endcase
                    end
                    or_n = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    took_n = iv_n && ir_n;
                    if (took_n) acc_n++;
                    @(posedge clk);
                    #1;
                    cyc_n++;
                end
                iv_n = 1'b0;
                or_n = 1'b1;
                checks++;
                if (acc_n < N_RAND) begin
                    errors++;
                    $display("FAIL random_n_timeout: accepts=%0d, required %0d", acc_n, N_RAND);
                end
            end
        join
        for (int n = 0; n < 60 && (q_w.size() != 0 || q_n.size() != 0 || ov_w || ov_n); n++) cycle();
        checks++;
        if (q_w.size() != 0 || q_n.size() != 0) begin
            errors++;
            $display("FAIL random_drain: outstanding w=%0d n=%0d, required 0 0", q_w.size(), q_n.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv_w = 1'b0; a_w = '0; b_w = '0; bin_w = 1'b0; or_w = 1'b1;
        iv_n = 1'b0; a_n = '0; b_n = '0; bin_n = 1'b0; or_n = 1'b1;
        test_reset_state();
        test_basic();
        test_borrow();
        test_reset_mid();
        test_back_pressure();
        test_bubbles();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
